// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  uart_tx_arbiter
//  Round-robin sharing of one uart_tx serializer between NUM_REQ byte
//  producers; optional sticky ownership when UART_TX_ARB_LOCK_EN is defined.
//  Revision: 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]     req_lock_i,
`endif
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   tx_e_o,
  output logic [7:0]             tx_d_o,
  input  logic                   tx_busy_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_arb;
  logic [IDX_W-1:0]   r_rr;
  logic [IDX_W-1:0]   r_win;
  logic [NUM_REQ-1:0] r_grant;
  logic [7:0]         r_txd;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   w_rr_win;
  logic [IDX_W-1:0]   w_sel;
  int                 w_idx;

  // First valid requester at or above the pointer, wrapping around.
  always_comb begin
    w_rr_win = '0;
    w_idx    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = int'(r_rr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (req_valid_i[w_idx]) w_rr_win = IDX_W'(w_idx);
    end
  end

`ifdef UART_TX_ARB_LOCK_EN
  logic       r_locked;
  logic [7:0] r_lock_cnt;
  logic       w_lock_hit;

  assign w_lock_hit = req_lock_i[r_win] && req_valid_i[r_win] && (r_lock_cnt != 8'hFF);
  assign w_sel      = w_lock_hit ? r_win : w_rr_win;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_locked   <= 1'b0;
      r_lock_cnt <= 8'h00;
    end else if (w_arb) begin
      r_locked   <= w_lock_hit;
      r_lock_cnt <= w_lock_hit ? r_lock_cnt + 8'h01 : 8'h00;
    end
  end
`else
  assign w_sel = w_rr_win;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_arb       = 1'b0;
    tx_e_o      = 1'b0;
    req_ready_o = '0;
    err_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!tx_busy_i && (|req_valid_i)) begin
          w_arb  = 1'b1;
          w_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        tx_e_o      = 1'b1;
        req_ready_o = r_grant;
        w_next      = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy_i) begin
          w_next = S_WAIT_DONE;
        end else if (r_cnt >= c_cnt_last) begin
          err_o  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr    <= '0;
      r_win   <= '0;
      r_grant <= '0;
      r_txd   <= 8'h00;
      r_cnt   <= '0;
    end else begin
      if (w_arb) begin
        r_win   <= w_sel;
        r_grant <= NUM_REQ'(1) << w_sel;
        r_txd   <= req_data_i[8*w_sel +: 8];
      end
      if (r_state == S_LAUNCH) begin
        r_cnt <= '0;
`ifdef UART_TX_ARB_LOCK_EN
        if (!r_locked)
`endif
        r_rr <= (r_win == c_idx_last) ? '0 : r_win + 1'b1;
      end
      if (r_state == S_WAIT_BUSY && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      if (r_state != S_IDLE && w_next == S_IDLE) r_grant <= '0;
    end
  end

  assign grant_o = r_grant;
  assign tx_d_o  = r_txd;
  assign busy_o  = (r_state != S_IDLE);

endmodule
`default_nettype wire
